i2c_target: RTL

- I2C target (slave) that answers the bus controller on the shared open-drain `sda`/`scl` lines.
- Matches a fixed 7-bit address and supports write transfers (controller→target) and read transfers (target→controller).
- Supports multi-byte transfers, repeated START and STOP.
- Sits behind the shared bus lines and presents a byte-level streaming interface to the local register/FIFO logic. No clock stretching.

---
 rtl/i2c_target.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// i2c_target: I2C target with a fixed 7-bit address and a byte-streaming rx/tx interface.
// sda is only ever pulled low; scl is sampled only (no clock stretching).
module i2c_target #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 7'h42
) (
   input  logic                  clock,
   input  logic                  reset_n,
   inout  wire                   sda,
   inout  wire                   scl,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_load,
   output logic                  rw,
   output logic                  busy,
   output logic                  tx_underrun,
   output logic                  start_det,
   output logic                  stop_det
);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, ADDR_ACK = 3'd2, WRITE = 3'd3,
                          WRITE_ACK = 3'd4, READ = 3'd5, READ_ACK = 3'd6, IGNORE = 3'd7;
   logic [2:0] state;
   logic scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h;
   logic [DATA_WIDTH-1:0] sh, in_byte, tx_byte;
   logic [CW-1:0] cnt;
   logic sda_oe, ph, ack_pend;
   logic scl_rise, scl_fall, start, stop, last_bit;

   assign sda = sda_oe ? 1'b0 : 1'bz;
   assign scl = 1'bz;
   assign scl_rise = scl_s2 & ~scl_h;
   assign scl_fall = ~scl_s2 & scl_h;
   assign start = scl_s2 & sda_h & ~sda_s2;
   assign stop = scl_s2 & ~sda_h & sda_s2;
   assign last_bit = cnt == CW'(DATA_WIDTH - 1);
   assign in_byte = {sh[DATA_WIDTH-2:0], sda_s2};
   assign tx_byte = tx_valid ? tx_data : '1;
   // ph marks the second SCL fall of an ACK slot, where the slot is handed back
   assign tx_load = scl_fall & ((state == ADDR_ACK & ph & rw) | state == READ_ACK);

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) {scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h} <= '1;
      else {scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h} <= {scl, scl_s1, scl_s2, sda, sda_s1, sda_s2};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         sh <= '0;
         cnt <= '0;
         sda_oe <= 1'b0;
         ph <= 1'b0;
         ack_pend <= 1'b0;
         rw <= 1'b0;
         busy <= 1'b0;
         rx_data <= '0;
         rx_valid <= 1'b0;
         tx_underrun <= 1'b0;
         start_det <= 1'b0;
         stop_det <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         start_det <= start;
         stop_det <= stop;
         if (start) begin
            state <= ADDR;
            sda_oe <= 1'b0;
            cnt <= '0;
            busy <= 1'b0;
         end else if (stop) begin
            state <= IDLE;
            sda_oe <= 1'b0;
            busy <= 1'b0;
         end else if (tx_load) begin
            state <= READ;
            sh <= {tx_byte[DATA_WIDTH-2:0], 1'b0};
            sda_oe <= ~tx_byte[DATA_WIDTH-1];
            cnt <= CW'(1);
            tx_underrun <= tx_underrun | ~tx_valid;
         end else begin
            case (state)
               ADDR: if (scl_rise) begin
                  sh <= in_byte;
                  cnt <= cnt + 1'b1;
                  ph <= 1'b0;
                  if (last_bit) begin
                     if (sh[ADDR_WIDTH-1:0] == TARGET_ADDR) begin
                        rw <= sda_s2;
                        state <= ADDR_ACK;
                     end else state <= IGNORE;
                  end
               end
               ADDR_ACK: if (scl_fall) begin
                  if (!ph) begin
                     sda_oe <= 1'b1;
                     busy <= 1'b1;
                     ph <= 1'b1;
                  end else begin
                     sda_oe <= 1'b0;
                     cnt <= '0;
                     state <= WRITE;
                  end
               end
               WRITE: if (scl_rise) begin
                  sh <= in_byte;
                  cnt <= cnt + 1'b1;
                  if (last_bit) begin
                     if (rx_ready) rx_data <= in_byte;
                     rx_valid <= rx_ready;
                     ack_pend <= rx_ready;
                     ph <= 1'b0;
                     state <= WRITE_ACK;
                  end
               end
               WRITE_ACK: if (scl_fall) begin
                  if (!ph) begin
                     sda_oe <= ack_pend;
                     ph <= 1'b1;
                  end else begin
                     sda_oe <= 1'b0;
                     cnt <= '0;
                     busy <= ack_pend;
                     state <= ack_pend ? WRITE : IGNORE;
                  end
               end
               READ: if (scl_fall) begin
                  if (cnt == CW'(DATA_WIDTH)) begin
                     sda_oe <= 1'b0;
                     state <= READ_ACK;
                  end else begin
                     sda_oe <= ~sh[DATA_WIDTH-1];
                     sh <= sh << 1;
                     cnt <= cnt + 1'b1;
                  end
               end
               READ_ACK: if (scl_rise && sda_s2) begin
                  busy <= 1'b0;
                  state <= IGNORE;
               end
               default: ;
            endcase
         end
      end
   end
endmodule
